// File: rtl/odata_frame_packer_if.sv
// Stream bundle between the upstream output stage, the frame packer and the AXI-stream sink.
// The slave view is the packer itself; the master view is whatever drives idata and consumes the stream.
interface odata_frame_packer_if #(
  parameter int DSIZE = 8
);
  logic [DSIZE-1:0] idata;
  logic             ivalid;
  logic [DSIZE-1:0] axis_tdata;
  logic             axis_tvalid;
  logic             axis_tready;
  logic             axis_tlast;

  modport slave (
    input  idata,
    input  ivalid,
    input  axis_tready,
    output axis_tdata,
    output axis_tvalid,
    output axis_tlast
  );

  modport master (
    output idata,
    output ivalid,
    output axis_tready,
    input  axis_tdata,
    input  axis_tvalid,
    input  axis_tlast
  );
endinterface

// File: rtl/odata_frame_packer.sv
// Buffers a non-stallable word stream in a small FWFT FIFO and emits it as AXI-stream
// frames of FRAME_LEN beats, with a sticky drop flag and a completed-frame counter.
module odata_frame_packer #(
  parameter int DSIZE      = 8,
  parameter int FRAME_LEN  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  odata_frame_packer_if.slave   bus,
  output logic                  overflow,
  output logic [15:0]           frame_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [OW-1:0] DEPTH_CNT = OW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);

  logic [DSIZE-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [OW-1:0]    occ;
  logic [BW-1:0]    beat_cnt;
  logic [15:0]      frame_cnt_q;
  logic             overflow_q;

  logic full;
  logic empty;
  logic wr_en;
  logic pop;
  logic last_beat;

  // Full is judged on occupancy at the start of the cycle, so a same-cycle pop never rescues a word.
  assign full      = (occ == DEPTH_CNT);
  assign empty     = (occ == '0);
  assign wr_en     = bus.ivalid & ~full;
  assign pop       = ~empty & bus.axis_tready;
  assign last_beat = (beat_cnt == LAST_BEAT);

  // Data is gated by empty so the bus reads zero in reset and idle without resetting the array.
  assign bus.axis_tvalid = ~empty;
  assign bus.axis_tdata  = empty ? '0 : mem[rd_ptr];
  assign bus.axis_tlast  = ~empty & last_beat;
  assign overflow        = overflow_q;
  assign frame_cnt       = frame_cnt_q;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.idata;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Frame position advances on transfers only; input gaps and sink stalls leave it untouched.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt    <= '0;
      frame_cnt_q <= '0;
    end else if (pop) begin
      if (last_beat) begin
        beat_cnt    <= '0;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end else begin
        beat_cnt    <= beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (bus.ivalid && full) begin
      overflow_q <= 1'b1;
    end
  end
endmodule
